// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom pipeline: ULA op-codes, sequencer states
// and the default pixel width.
package zoom_pkg;

   localparam int W_DEF = 8;

   localparam logic [1:0] OP_SOMA = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

   // DIV and ACC are indexed by a separate pixel counter k.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DIV  = 2'b01,
      ACC  = 2'b10,
      DONE = 2'b11
   } estado_t;

endpackage

// File: rtl/controlador_media_ula.sv
// Sequences the external 8-bit ULA over one N-pixel window to produce either
// the block average sum(floor(p_k/N)) or the nearest-neighbour pixel p0.
module controlador_media_ula
   import zoom_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W*N-1:0] pix_in,
   input  logic           modo,
   output logic [W-1:0]   ula_A,
   output logic [W-1:0]   ula_B,
   output logic [1:0]     ula_op,
   input  logic [W-1:0]   ula_R,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_pix
);

   localparam int            KW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [W-1:0]  N_W    = W'(N);

   estado_t          estado, estado_nx;
   logic [KW-1:0]    k;
   logic [W*N-1:0]   janela;
   logic [W-1:0]     acc;
   logic [W-1:0]     q;

   // NOTE: state is updated with non-blocking assignments so every register
   // in this module sees the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= IDLE;
      else        estado <= estado_nx;
   end

   // ULA drive depends on registered state only; R never feeds back into A/B/op.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      estado_nx = estado;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      ula_A     = '0;
      ula_B     = W'(1);
      ula_op    = OP_SOMA;
      case (estado)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) estado_nx = modo ? DONE : DIV;
         end
         DIV: begin
            ula_A     = janela[k*W +: W];
            ula_B     = N_W;
            ula_op    = OP_DIV;
            estado_nx = ACC;
         end
         ACC: begin
            ula_A     = (k == '0) ? '0 : acc;
            ula_B     = q;
            ula_op    = OP_SOMA;
            estado_nx = (k == K_LAST) ? DONE : DIV;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) estado_nx = IDLE;
         end
         default: estado_nx = IDLE;
      endcase
   end

   // NOTE: the window and arithmetic registers are reset too, so an aborted
   // sequence leaves nothing stale behind for the next window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k       <= '0;
         janela  <= '0;
         acc     <= '0;
         q       <= '0;
         out_pix <= '0;
      end else begin
         case (estado)
            IDLE: begin
               if (in_valid) begin
                  janela <= pix_in;
                  k      <= '0;
                  if (modo) out_pix <= pix_in[W-1:0];
               end
            end
            DIV: q <= ula_R;
            ACC: begin
               acc <= ula_R;
               if (k == K_LAST) out_pix <= ula_R;
               else             k       <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_media_ula.sv
// Directed bench for controlador_media_ula with a behavioural ULA alongside it.
module tb_controlador_media_ula;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W*N-1:0] pix_in;
   logic           modo;
   logic [W-1:0]   ula_A, ula_B, ula_R;
   logic [1:0]     ula_op;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_pix;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   controlador_media_ula #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .pix_in(pix_in), .modo(modo),
      .ula_A(ula_A), .ula_B(ula_B), .ula_op(ula_op), .ula_R(ula_R),
      .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix)
   );

   always_comb begin
      case (ula_op)
         2'b00:   ula_R = ula_A + ula_B;
         2'b01:   ula_R = ula_A - ula_B;
         2'b10:   ula_R = ula_A * ula_B;
         default: ula_R = (ula_B == '0) ? '0 : ula_A / ula_B;
      endcase
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents a window and returns at the first negedge after the accept edge.
   task automatic accept(input logic [W*N-1:0] w, input logic m, output int t0);
      @(negedge clk);
      pix_in = w; modo = m; in_valid = 1'b1;
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      t0 = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; pix_in = '0; modo = 1'b0; out_ready = 1'b1;
      #12;
      checks++;
      if ({in_ready, out_valid, out_pix, ula_A, ula_B, ula_op} !== {1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 2'b00}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b pix=%0d A=%0d B=%0d op=%b expected 1 0 0 0 1 00",
                  in_ready, out_valid, out_pix, ula_A, ula_B, ula_op);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Average window with full ULA trace and latency check.
   task automatic test_average(input logic [W*N-1:0] w, input logic [W-1:0] expv, input string name);
      int t0;
      logic [W-1:0] acc_m, pk, ea, eb;
      logic [1:0] eop;
      acc_m = '0;
      out_ready = 1'b1;
      accept(w, 1'b0, t0);
      for (int s = 0; s < 2*N; s++) begin
         pk = w[(s/2)*W +: W];
         if (s % 2 == 0) begin
            ea = pk; eb = W'(N); eop = 2'b11;
         end else begin
            ea = acc_m; eb = pk / W'(N); eop = 2'b00;
            acc_m = acc_m + eb;
         end
         checks++;
         if ({out_valid, ula_op, ula_A, ula_B} !== {1'b0, eop, ea, eb}) begin
            errors++;
            $display("FAIL %s_trace%0d: vld=%b op=%b A=%0d B=%0d expected 0 %b %0d %0d",
                     name, s, out_valid, ula_op, ula_A, ula_B, eop, ea, eb);
         end
         @(negedge clk);
      end
      checks++;
      if ({out_valid, out_pix} !== {1'b1, expv} || cyc - t0 != 2*N) begin
         errors++;
         $display("FAIL %s_result: vld=%b pix=%0d lat=%0d expected 1 %0d %0d",
                  name, out_valid, out_pix, cyc - t0, expv, 2*N);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s_release: vld=%b rdy=%b expected 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_replication();
      int t0;
      out_ready = 1'b1;
      accept({8'd41, 8'd30, 8'd20, 8'd10}, 1'b1, t0);
      checks++;
      if ({out_valid, in_ready, out_pix, ula_A, ula_B, ula_op} !== {1'b1, 1'b0, 8'd10, 8'd0, 8'd1, 2'b00}) begin
         errors++;
         $display("FAIL replication: vld=%b rdy=%b pix=%0d A=%0d B=%0d op=%b expected 1 0 10 0 1 00",
                  out_valid, in_ready, out_pix, ula_A, ula_B, ula_op);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL replication_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      int t0;
      out_ready = 1'b0;
      accept({8'd80, 8'd70, 8'd60, 8'd50}, 1'b0, t0);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin in_valid = 1'b1; pix_in = {4{8'd200}}; modo = 1'b1; end
         if (i == 3) in_valid = 1'b0;
         checks++;
         if ({out_valid, in_ready, out_pix, ula_A, ula_B, ula_op} !== {1'b1, 1'b0, 8'd64, 8'd0, 8'd1, 2'b00}) begin
            errors++;
            $display("FAIL backpressure_hold%0d: vld=%b rdy=%b pix=%0d A=%0d B=%0d op=%b expected 1 0 64 0 1 00",
                     i, out_valid, in_ready, out_pix, ula_A, ula_B, ula_op);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL backpressure_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL backpressure_ignored: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [W*N-1:0] wins [3];
      logic [W-1:0]   expv [3];
      int             t_acc [3];
      wins[0] = {8'd4, 8'd3, 8'd2, 8'd1};       expv[0] = 8'd1;
      wins[1] = {8'd8, 8'd8, 8'd8, 8'd8};       expv[1] = 8'd8;
      wins[2] = {8'd7, 8'd50, 8'd100, 8'd200};  expv[2] = 8'd88;
      @(negedge clk);
      out_ready = 1'b1; modo = 1'b0; pix_in = wins[0]; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 40 && !in_ready; j++) @(negedge clk);
         for (int j = 0; j < 40 && in_ready; j++) @(negedge clk);
         t_acc[i] = cyc;
         if (i < 2) pix_in = wins[i+1];
         else       in_valid = 1'b0;
         if (i > 0) begin
            checks++;
            if (t_acc[i] - t_acc[i-1] != 2*N + 2) begin
               errors++;
               $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d", i, t_acc[i] - t_acc[i-1], 2*N + 2);
            end
         end
         for (int j = 0; j < 40 && !out_valid; j++) @(negedge clk);
         checks++;
         if ({out_valid, out_pix} !== {1'b1, expv[i]}) begin
            errors++;
            $display("FAIL b2b_result%0d: vld=%b pix=%0d expected 1 %0d", i, out_valid, out_pix, expv[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int t0;
      out_ready = 1'b1;
      accept({4{8'd40}}, 1'b0, t0);
      repeat (5) @(negedge clk);
      checks++;
      if ({ula_op, ula_A, ula_B} !== {2'b00, 8'd20, 8'd10}) begin
         errors++;
         $display("FAIL reset_mid_acc2: op=%b A=%0d B=%0d expected 00 20 10", ula_op, ula_A, ula_B);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_pix, ula_A, ula_B, ula_op} !== {1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 2'b00}) begin
         errors++;
         $display("FAIL reset_mid_abort: rdy=%b vld=%b pix=%0d A=%0d B=%0d op=%b expected 1 0 0 0 1 00",
                  in_ready, out_valid, out_pix, ula_A, ula_B, ula_op);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_average({8'd25, 8'd20, 8'd16, 8'd12}, 8'd18, "after_reset");
   endtask

   initial begin
      test_reset();
      test_average({4{8'd100}}, 8'd100, "avg100");
      test_average({4{8'd255}}, 8'd252, "avg255");
      test_average({4{8'd3}},   8'd0,   "avg3");
      test_replication();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
